// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, strobe bit map
// and the sequencer state encoding.
package cpu_ctrl_pkg;

    localparam int OPW   = 5;
    localparam int NCTRL = 28;

    // Opcodes (IR[31:27])
    localparam logic [OPW-1:0] OP_LD   = 5'd0;
    localparam logic [OPW-1:0] OP_LDI  = 5'd1;
    localparam logic [OPW-1:0] OP_ST   = 5'd2;
    localparam logic [OPW-1:0] OP_ADD  = 5'd3;
    localparam logic [OPW-1:0] OP_SUB  = 5'd4;
    localparam logic [OPW-1:0] OP_AND  = 5'd5;
    localparam logic [OPW-1:0] OP_OR   = 5'd6;
    localparam logic [OPW-1:0] OP_ADDI = 5'd12;
    localparam logic [OPW-1:0] OP_ANDI = 5'd13;
    localparam logic [OPW-1:0] OP_ORI  = 5'd14;
    localparam logic [OPW-1:0] OP_MUL  = 5'd15;
    localparam logic [OPW-1:0] OP_DIV  = 5'd16;
    localparam logic [OPW-1:0] OP_BRX  = 5'd18;
    localparam logic [OPW-1:0] OP_JR   = 5'd19;
    localparam logic [OPW-1:0] OP_JAL  = 5'd20;
    localparam logic [OPW-1:0] OP_IN   = 5'd21;
    localparam logic [OPW-1:0] OP_OUT  = 5'd22;
    localparam logic [OPW-1:0] OP_MFHI = 5'd23;
    localparam logic [OPW-1:0] OP_MFLO = 5'd24;
    localparam logic [OPW-1:0] OP_NOP  = 5'd25;
    localparam logic [OPW-1:0] OP_HALT = 5'd26;

    // Control strobe bit positions within ctrl
    localparam int C_PCOUT      = 0;
    localparam int C_ZLOWOUT    = 1;
    localparam int C_ZHIGHOUT   = 2;
    localparam int C_MDROUT     = 3;
    localparam int C_HIOUT      = 4;
    localparam int C_LOOUT      = 5;
    localparam int C_INPORTOUT  = 6;
    localparam int C_BAOUT      = 7;
    localparam int C_COUT       = 8;
    localparam int C_ROUT       = 9;
    localparam int C_RIN        = 10;
    localparam int C_GRA        = 11;
    localparam int C_GRB        = 12;
    localparam int C_GRC        = 13;
    localparam int C_MAR_EN     = 14;
    localparam int C_PC_EN      = 15;
    localparam int C_MDR_EN     = 16;
    localparam int C_MDR_RD     = 17;
    localparam int C_IR_EN      = 18;
    localparam int C_Y_EN       = 19;
    localparam int C_INCPC      = 20;
    localparam int C_RAM_WR     = 21;
    localparam int C_HI_EN      = 22;
    localparam int C_LO_EN      = 23;
    localparam int C_ZHIGHIN    = 24;
    localparam int C_ZLOWIN     = 25;
    localparam int C_CON_EN     = 26;
    localparam int C_OUTPORT_EN = 27;

    typedef enum logic [3:0] {
        RST, T0, T1, T2, T3, T4, T5, T6, T7, HALTED
    } state_t;

    // True for opcodes that own execute steps; nop and undefined codes end at T2.
    function automatic logic has_exec(input logic [OPW-1:0] op);
        case (op)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ADDI, OP_ANDI, OP_ORI, OP_MUL, OP_DIV, OP_BRX, OP_JR,
            OP_JAL, OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_HALT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface control_sequencer_if;
    import cpu_ctrl_pkg::*;

    logic [31:0]      IR;
    logic             CON_FF;
    logic             Stop;
    logic [NCTRL-1:0] ctrl;
    logic [OPW-1:0]   alu_op;
    logic             Run;
    logic [2:0]       step;

    modport master (input IR, CON_FF, Stop, output ctrl, alu_op, Run, step);
    modport slave  (output IR, CON_FF, Stop, input ctrl, alu_op, Run, step);
endinterface

// File: rtl/control_sequencer_exec_decode.sv
// Combinational microstep table: (opcode, T-step, CON_FF) -> strobes, ALU op,
// end-of-instruction and halt flags. Covers fetch as well as execute steps.
module exec_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OPW-1:0]   i_op,
    input  logic [2:0]       i_step,
    input  logic             i_con,
    output logic [NCTRL-1:0] o_ctrl,
    output logic [OPW-1:0]   o_alu_op,
    output logic             o_last,
    output logic             o_halt
);

    // Decode one microstep; every unlisted strobe stays low.
    always_comb begin
        o_ctrl   = '0;
        o_alu_op = '0;
        o_last   = 1'b0;
        o_halt   = 1'b0;
        case (i_step)
            3'd0: begin
                o_ctrl[C_PCOUT] = 1'b1; o_ctrl[C_MAR_EN] = 1'b1;
                o_ctrl[C_INCPC] = 1'b1; o_ctrl[C_ZLOWIN] = 1'b1;
            end
            3'd1: begin
                o_ctrl[C_ZLOWOUT] = 1'b1; o_ctrl[C_PC_EN]  = 1'b1;
                o_ctrl[C_MDR_RD]  = 1'b1; o_ctrl[C_MDR_EN] = 1'b1;
            end
            3'd2: begin
                o_ctrl[C_MDROUT] = 1'b1; o_ctrl[C_IR_EN] = 1'b1;
                o_last = !has_exec(i_op);
            end
            default: begin
                case (i_op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
                        case (i_step)
                            3'd3: begin o_ctrl[C_GRB] = 1'b1; o_ctrl[C_ROUT] = 1'b1; o_ctrl[C_Y_EN] = 1'b1; end
                            3'd4: begin
                                if (i_op inside {OP_ADDI, OP_ANDI, OP_ORI}) o_ctrl[C_COUT] = 1'b1;
                                else begin o_ctrl[C_GRC] = 1'b1; o_ctrl[C_ROUT] = 1'b1; end
                                o_ctrl[C_ZLOWIN] = 1'b1; o_alu_op = i_op;
                            end
                            3'd5: begin o_ctrl[C_ZLOWOUT] = 1'b1; o_ctrl[C_GRA] = 1'b1; o_ctrl[C_RIN] = 1'b1; o_last = 1'b1; end
                            default: o_last = 1'b1;
                        endcase
                    end
                    OP_MUL, OP_DIV: begin
                        case (i_step)
                            3'd3: begin o_ctrl[C_GRA] = 1'b1; o_ctrl[C_ROUT] = 1'b1; o_ctrl[C_Y_EN] = 1'b1; end
                            3'd4: begin
                                o_ctrl[C_GRB] = 1'b1; o_ctrl[C_ROUT] = 1'b1;
                                o_ctrl[C_ZHIGHIN] = 1'b1; o_ctrl[C_ZLOWIN] = 1'b1; o_alu_op = i_op;
                            end
                            3'd5: begin o_ctrl[C_ZLOWOUT] = 1'b1; o_ctrl[C_LO_EN] = 1'b1; end
                            3'd6: begin o_ctrl[C_ZHIGHOUT] = 1'b1; o_ctrl[C_HI_EN] = 1'b1; o_last = 1'b1; end
                            default: o_last = 1'b1;
                        endcase
                    end
                    OP_LD, OP_LDI, OP_ST: begin
                        case (i_step)
                            3'd3: begin o_ctrl[C_GRB] = 1'b1; o_ctrl[C_BAOUT] = 1'b1; o_ctrl[C_Y_EN] = 1'b1; end
                            3'd4: begin o_ctrl[C_COUT] = 1'b1; o_ctrl[C_ZLOWIN] = 1'b1; o_alu_op = OP_ADD; end
                            3'd5: begin
                                o_ctrl[C_ZLOWOUT] = 1'b1;
                                if (i_op == OP_LDI) begin o_ctrl[C_GRA] = 1'b1; o_ctrl[C_RIN] = 1'b1; o_last = 1'b1; end
                                else o_ctrl[C_MAR_EN] = 1'b1;
                            end
                            3'd6: begin
                                o_ctrl[C_MDR_EN] = 1'b1;
                                if (i_op == OP_ST) begin o_ctrl[C_GRA] = 1'b1; o_ctrl[C_ROUT] = 1'b1; end
                                else o_ctrl[C_MDR_RD] = 1'b1;
                            end
                            default: begin
                                if (i_op == OP_ST) o_ctrl[C_RAM_WR] = 1'b1;
                                else begin o_ctrl[C_MDROUT] = 1'b1; o_ctrl[C_GRA] = 1'b1; o_ctrl[C_RIN] = 1'b1; end
                                o_last = 1'b1;
                            end
                        endcase
                    end
                    OP_BRX: begin
                        case (i_step)
                            3'd3: begin o_ctrl[C_GRA] = 1'b1; o_ctrl[C_ROUT] = 1'b1; o_ctrl[C_CON_EN] = 1'b1; end
                            3'd4: begin o_ctrl[C_PCOUT] = 1'b1; o_ctrl[C_Y_EN] = 1'b1; end
                            3'd5: begin o_ctrl[C_COUT] = 1'b1; o_ctrl[C_ZLOWIN] = 1'b1; o_alu_op = OP_ADD; end
                            3'd6: begin o_ctrl[C_ZLOWOUT] = 1'b1; o_ctrl[C_PC_EN] = i_con; o_last = 1'b1; end
                            default: o_last = 1'b1;
                        endcase
                    end
                    OP_JAL: begin
                        if (i_step == 3'd3) begin o_ctrl[C_PCOUT] = 1'b1; o_ctrl[C_GRB] = 1'b1; o_ctrl[C_RIN] = 1'b1; end
                        else begin o_ctrl[C_GRA] = 1'b1; o_ctrl[C_ROUT] = 1'b1; o_ctrl[C_PC_EN] = 1'b1; o_last = 1'b1; end
                    end
                    OP_JR:   begin o_ctrl[C_GRA] = 1'b1; o_ctrl[C_ROUT] = 1'b1; o_ctrl[C_PC_EN] = 1'b1; o_last = 1'b1; end
                    OP_IN:   begin o_ctrl[C_INPORTOUT] = 1'b1; o_ctrl[C_GRA] = 1'b1; o_ctrl[C_RIN] = 1'b1; o_last = 1'b1; end
                    OP_OUT:  begin o_ctrl[C_GRA] = 1'b1; o_ctrl[C_ROUT] = 1'b1; o_ctrl[C_OUTPORT_EN] = 1'b1; o_last = 1'b1; end
                    OP_MFHI: begin o_ctrl[C_HIOUT] = 1'b1; o_ctrl[C_GRA] = 1'b1; o_ctrl[C_RIN] = 1'b1; o_last = 1'b1; end
                    OP_MFLO: begin o_ctrl[C_LOOUT] = 1'b1; o_ctrl[C_GRA] = 1'b1; o_ctrl[C_RIN] = 1'b1; o_last = 1'b1; end
                    OP_HALT: o_halt = 1'b1;
                    default: o_last = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore sequencer: state register, Stop/halt handling, and output
// gating. Strobes come straight from the decode table, forced to zero outside T0..T7.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic                 Clock,
    input  logic                 Clear,
    control_sequencer_if.master  bus
);

    state_t           r_state;
    state_t           w_next;
    logic             w_in_t;
    logic [2:0]       w_step;
    logic [NCTRL-1:0] w_ctrl;
    logic [OPW-1:0]   w_alu_op;
    logic             w_last;
    logic             w_halt;
    logic             w_unused_ir;

    assign w_unused_ir = ^bus.IR[26:0];
    assign w_in_t      = (r_state != RST) && (r_state != HALTED);
    assign w_step      = w_in_t ? 3'(r_state - T0) : 3'd0;

    exec_decode u_dec (
        .i_op     (bus.IR[31:27]),
        .i_step   (w_step),
        .i_con    (bus.CON_FF),
        .o_ctrl   (w_ctrl),
        .o_alu_op (w_alu_op),
        .o_last   (w_last),
        .o_halt   (w_halt)
    );

    assign bus.ctrl   = w_in_t ? w_ctrl   : '0;
    assign bus.alu_op = w_in_t ? w_alu_op : '0;
    assign bus.Run    = (r_state != HALTED);
    assign bus.step   = w_step;

    // State register; Clear aborts any instruction asynchronously.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) r_state <= RST;
        else       r_state <= w_next;
    end

    // Next step: advance, wrap to T0 at the last step, or halt (Stop only at instruction end).
    always_comb begin
        w_next = r_state;
        case (r_state)
            RST:    w_next = T0;
            HALTED: w_next = HALTED;
            default: begin
                if (w_halt)                          w_next = HALTED;
                else if (w_last || r_state == T7)    w_next = bus.Stop ? HALTED : T0;
                else                                 w_next = state_t'(r_state + 4'd1);
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios plus a randomized stream of
// instructions checked against a per-instruction microprogram reference.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    typedef struct packed {
        logic [27:0] c;
        logic [4:0]  a;
    } stp_t;

    logic Clock = 1'b0;
    logic Clear = 1'b1;
    int   checks = 0;
    int   errors = 0;

    stp_t exp_q[$];
    bit   exp_halt;
    logic [27:0] t0c;

    control_sequencer_if bus();
    control_sequencer dut (.Clock(Clock), .Clear(Clear), .bus(bus));

    always #5 Clock = ~Clock;

    function automatic logic [27:0] sb(input int i);
        return 28'(1) << i;
    endfunction

    task automatic tick();
        @(posedge Clock); #1;
    endtask

    task automatic do_clear();
        Clear = 1'b1; #2; Clear = 1'b0; tick();
    endtask

    task automatic set_ir(input logic [4:0] op);
        bus.IR = {op, 27'($urandom)};
    endtask

    task automatic push(input logic [27:0] c, input logic [4:0] a = 5'd0);
        exp_q.push_back('{c: c, a: a});
    endtask

    // Reference microprogram: full list of steps for one instruction, T0 first.
    task automatic build(input logic [4:0] op, input logic con);
        exp_q.delete(); exp_halt = 0;
        push(sb(C_PCOUT) | sb(C_MAR_EN) | sb(C_INCPC) | sb(C_ZLOWIN));
        push(sb(C_ZLOWOUT) | sb(C_PC_EN) | sb(C_MDR_RD) | sb(C_MDR_EN));
        push(sb(C_MDROUT) | sb(C_IR_EN));
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                push(sb(C_GRB) | sb(C_ROUT) | sb(C_Y_EN));
                push(sb(C_GRC) | sb(C_ROUT) | sb(C_ZLOWIN), op);
                push(sb(C_ZLOWOUT) | sb(C_GRA) | sb(C_RIN));
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                push(sb(C_GRB) | sb(C_ROUT) | sb(C_Y_EN));
                push(sb(C_COUT) | sb(C_ZLOWIN), op);
                push(sb(C_ZLOWOUT) | sb(C_GRA) | sb(C_RIN));
            end
            OP_MUL, OP_DIV: begin
                push(sb(C_GRA) | sb(C_ROUT) | sb(C_Y_EN));
                push(sb(C_GRB) | sb(C_ROUT) | sb(C_ZHIGHIN) | sb(C_ZLOWIN), op);
                push(sb(C_ZLOWOUT) | sb(C_LO_EN));
                push(sb(C_ZHIGHOUT) | sb(C_HI_EN));
            end
            OP_LD, OP_LDI, OP_ST: begin
                push(sb(C_GRB) | sb(C_BAOUT) | sb(C_Y_EN));
                push(sb(C_COUT) | sb(C_ZLOWIN), 5'd3);
                if (op == OP_LDI) push(sb(C_ZLOWOUT) | sb(C_GRA) | sb(C_RIN));
                else begin
                    push(sb(C_ZLOWOUT) | sb(C_MAR_EN));
                    if (op == OP_LD) begin
                        push(sb(C_MDR_RD) | sb(C_MDR_EN));
                        push(sb(C_MDROUT) | sb(C_GRA) | sb(C_RIN));
                    end else begin
                        push(sb(C_GRA) | sb(C_ROUT) | sb(C_MDR_EN));
                        push(sb(C_RAM_WR));
                    end
                end
            end
            OP_BRX: begin
                push(sb(C_GRA) | sb(C_ROUT) | sb(C_CON_EN));
                push(sb(C_PCOUT) | sb(C_Y_EN));
                push(sb(C_COUT) | sb(C_ZLOWIN), 5'd3);
                push(sb(C_ZLOWOUT) | (con ? sb(C_PC_EN) : 28'd0));
            end
            OP_JR:   push(sb(C_GRA) | sb(C_ROUT) | sb(C_PC_EN));
            OP_JAL: begin
                push(sb(C_PCOUT) | sb(C_GRB) | sb(C_RIN));
                push(sb(C_GRA) | sb(C_ROUT) | sb(C_PC_EN));
            end
            OP_IN:   push(sb(C_INPORTOUT) | sb(C_GRA) | sb(C_RIN));
            OP_OUT:  push(sb(C_GRA) | sb(C_ROUT) | sb(C_OUTPORT_EN));
            OP_MFHI: push(sb(C_HIOUT) | sb(C_GRA) | sb(C_RIN));
            OP_MFLO: push(sb(C_LOOUT) | sb(C_GRA) | sb(C_RIN));
            OP_HALT: begin push(28'd0); exp_halt = 1; end
            default: ;
        endcase
    endtask

    task automatic test_reset();
        bus.IR = 32'd0; bus.CON_FF = 1'b0; bus.Stop = 1'b0;
        tick(); #2;
        checks++;
        if (bus.step !== 3'd0 || bus.ctrl !== 28'd0 || bus.alu_op !== 5'd0 || bus.Run !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: step=%0d ctrl=%h alu=%0d run=%b, want 0/0/0/1", bus.step, bus.ctrl, bus.alu_op, bus.Run);
        end
        Clear = 1'b0; #1;
        checks++;
        if (bus.ctrl !== 28'd0 || bus.step !== 3'd0) begin
            errors++;
            $display("FAIL reset_release: ctrl=%h step=%0d, want 0/0 before first edge", bus.ctrl, bus.step);
        end
        tick();
        checks++;
        if (bus.step !== 3'd0 || bus.ctrl !== t0c) begin
            errors++;
            $display("FAIL reset_to_t0: step=%0d ctrl=%h, want 0/%h", bus.step, bus.ctrl, t0c);
        end
    endtask

    task automatic test_add();
        set_ir(OP_ADD); bus.CON_FF = 1'b0; do_clear();
        build(OP_ADD, 1'b0);
        foreach (exp_q[i]) begin
            checks++;
            if (bus.step !== 3'(i) || bus.ctrl !== exp_q[i].c || bus.alu_op !== exp_q[i].a) begin
                errors++;
                $display("FAIL add_T%0d: step=%0d ctrl=%h alu=%0d, want %0d/%h/%0d", i, bus.step, bus.ctrl, bus.alu_op, i, exp_q[i].c, exp_q[i].a);
            end
            tick();
        end
        checks++;
        if (bus.step !== 3'd0 || bus.ctrl !== t0c) begin
            errors++;
            $display("FAIL add_wrap: step=%0d ctrl=%h, want 0/%h", bus.step, bus.ctrl, t0c);
        end
    endtask

    task automatic test_ld();
        set_ir(OP_LD); do_clear();
        build(OP_LD, 1'b0);
        foreach (exp_q[i]) begin
            checks++;
            if (bus.step !== 3'(i) || bus.ctrl !== exp_q[i].c || bus.alu_op !== exp_q[i].a) begin
                errors++;
                $display("FAIL ld_T%0d: step=%0d ctrl=%h alu=%0d, want %0d/%h/%0d", i, bus.step, bus.ctrl, bus.alu_op, i, exp_q[i].c, exp_q[i].a);
            end
            if (i == 6) begin
                checks++;
                if (bus.ctrl[C_MDR_RD] !== 1'b1 || bus.ctrl[C_MDR_EN] !== 1'b1) begin
                    errors++;
                    $display("FAIL ld_T6_mdr: rd=%b en=%b, want 1/1", bus.ctrl[C_MDR_RD], bus.ctrl[C_MDR_EN]);
                end
            end
            tick();
        end
        checks++;
        if (bus.step !== 3'd0 || bus.ctrl !== t0c) begin
            errors++;
            $display("FAIL ld_9th_edge_t0: step=%0d ctrl=%h, want 0/%h", bus.step, bus.ctrl, t0c);
        end
    endtask

    task automatic test_brx();
        for (int k = 0; k < 2; k++) begin
            set_ir(OP_BRX); bus.CON_FF = (k == 0); do_clear();
            repeat (6) tick();
            checks++;
            if (bus.step !== 3'd6 || bus.ctrl[C_ZLOWOUT] !== 1'b1 || bus.ctrl[C_PC_EN] !== (k == 0)) begin
                errors++;
                $display("FAIL brx_T6_con%0d: step=%0d zlowout=%b pc_en=%b, want 6/1/%b", (k == 0), bus.step, bus.ctrl[C_ZLOWOUT], bus.ctrl[C_PC_EN], (k == 0));
            end
        end
        bus.CON_FF = 1'b0;
    endtask

    task automatic test_mflo();
        set_ir(OP_MFLO); do_clear();
        repeat (3) tick();
        checks++;
        if (bus.step !== 3'd3 || bus.ctrl !== (sb(C_LOOUT) | sb(C_GRA) | sb(C_RIN))) begin
            errors++;
            $display("FAIL mflo_T3: step=%0d ctrl=%h, want 3/%h", bus.step, bus.ctrl, sb(C_LOOUT) | sb(C_GRA) | sb(C_RIN));
        end
        tick();
        checks++;
        if (bus.step !== 3'd0 || bus.ctrl !== t0c) begin
            errors++;
            $display("FAIL mflo_wrap: step=%0d ctrl=%h, want 0/%h", bus.step, bus.ctrl, t0c);
        end
    endtask

    task automatic test_stop_mul();
        set_ir(OP_MUL); do_clear();
        repeat (4) tick();
        bus.Stop = 1'b1;
        tick(); tick();
        checks++;
        if (bus.step !== 3'd6 || bus.ctrl[C_HI_EN] !== 1'b1 || bus.Run !== 1'b1) begin
            errors++;
            $display("FAIL stop_mul_T6: step=%0d hi_en=%b run=%b, want 6/1/1", bus.step, bus.ctrl[C_HI_EN], bus.Run);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.Run !== 1'b0 || bus.ctrl !== 28'd0) begin
                errors++;
                $display("FAIL stop_mul_halted%0d: run=%b ctrl=%h, want 0/0", k, bus.Run, bus.ctrl);
            end
        end
        bus.Stop = 1'b0; set_ir(OP_NOP); do_clear();
        checks++;
        if (bus.Run !== 1'b1 || bus.ctrl !== t0c) begin
            errors++;
            $display("FAIL stop_mul_clear: run=%b ctrl=%h, want 1/%h", bus.Run, bus.ctrl, t0c);
        end
    endtask

    task automatic test_clear_st();
        set_ir(OP_ST); do_clear();
        repeat (6) tick();
        checks++;
        if (bus.step !== 3'd6 || bus.ctrl[C_MDR_EN] !== 1'b1) begin
            errors++;
            $display("FAIL st_T6: step=%0d mdr_en=%b, want 6/1", bus.step, bus.ctrl[C_MDR_EN]);
        end
        #2; Clear = 1'b1; #1;
        checks++;
        if (bus.ctrl !== 28'd0 || bus.step !== 3'd0) begin
            errors++;
            $display("FAIL st_async_clear: ctrl=%h step=%0d, want 0/0", bus.ctrl, bus.step);
        end
        tick();
        checks++;
        if (bus.ctrl[C_RAM_WR] !== 1'b0 || bus.ctrl !== 28'd0) begin
            errors++;
            $display("FAIL st_no_ramwr: ctrl=%h, want 0", bus.ctrl);
        end
        Clear = 1'b0;
        tick();
        checks++;
        if (bus.step !== 3'd0 || bus.ctrl !== t0c) begin
            errors++;
            $display("FAIL st_restart: step=%0d ctrl=%h, want 0/%h", bus.step, bus.ctrl, t0c);
        end
    endtask

    task automatic test_random();
        logic [4:0] op;
        logic       con, stp;
        set_ir(OP_NOP); do_clear();
        for (int n = 0; n < 60; n++) begin
            op = 5'($urandom_range(0, 31));
            con = 1'($urandom);
            stp = ($urandom_range(0, 5) == 0);
            set_ir(op); bus.CON_FF = con; bus.Stop = stp;
            build(op, con);
            foreach (exp_q[i]) begin
                checks++;
                if (bus.step !== 3'(i) || bus.ctrl !== exp_q[i].c || bus.alu_op !== exp_q[i].a || bus.Run !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_op%0d_T%0d: step=%0d ctrl=%h alu=%0d run=%b, want %0d/%h/%0d/1", op, i, bus.step, bus.ctrl, bus.alu_op, bus.Run, i, exp_q[i].c, exp_q[i].a);
                end
                tick();
            end
            if (exp_halt || stp) begin
                for (int k = 0; k < 2; k++) begin
                    checks++;
                    if (bus.Run !== 1'b0 || bus.ctrl !== 28'd0 || bus.alu_op !== 5'd0) begin
                        errors++;
                        $display("FAIL rand_op%0d_halt: run=%b ctrl=%h alu=%0d, want 0/0/0", op, bus.Run, bus.ctrl, bus.alu_op);
                    end
                    tick();
                end
                bus.Stop = 1'b0; do_clear();
            end else begin
                checks++;
                if (bus.step !== 3'd0 || bus.ctrl !== t0c || bus.Run !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_op%0d_wrap: step=%0d ctrl=%h run=%b, want 0/%h/1", op, bus.step, bus.ctrl, bus.Run, t0c);
                end
            end
        end
        bus.Stop = 1'b0;
    endtask

    initial begin
        t0c = sb(C_PCOUT) | sb(C_MAR_EN) | sb(C_INCPC) | sb(C_ZLOWIN);
        test_reset();
        test_add();
        test_ld();
        test_brx();
        test_mflo();
        test_stop_mul();
        test_clear_st();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
